// File: rtl/vga_source_arbiter.sv
// Frame-synchronous selector between two VGA renderers sharing one output.
// Source changes only on a vsync falling edge of the active source; colour is blanked while the monitor re-locks.
module vga_source_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter int unsigned AUTO_FRAMES     = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_sw,
    input  logic       auto_en,
    input  logic [2:0] src0_red,
    input  logic [2:0] src0_green,
    input  logic [1:0] src0_blue,
    input  logic       src0_hsync,
    input  logic       src0_vsync,
    input  logic [2:0] src1_red,
    input  logic [2:0] src1_green,
    input  logic [1:0] src1_blue,
    input  logic       src1_hsync,
    input  logic       src1_vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       active_src,
    output logic       switching
);

    localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BLANK_W = (BLANK_FRAMES > 2) ? $clog2(BLANK_FRAMES) : 1;
    localparam int unsigned AUTO_W  = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;

    typedef enum logic [1:0] {
        ST_STABLE    = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_BLANK     = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 active_q, active_d;
    logic                 switching_q, switching_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;

    logic                 sw_meta_q, sw_sync_q;
    logic                 deb_q, deb_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;

    logic [AUTO_W-1:0]    auto_cnt_q, auto_cnt_d;
    logic                 auto_tgt_q, auto_tgt_d;

    logic                 vs0_prev_q, vs1_prev_q;
    logic                 vs_fall0, vs_fall1, vs_fall_act;
    logic                 target;

    logic [2:0]           red_q, red_d;
    logic [2:0]           green_q, green_d;
    logic [1:0]           blue_q, blue_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;

    assign vs_fall0    = vs0_prev_q & ~src0_vsync;
    assign vs_fall1    = vs1_prev_q & ~src1_vsync;
    assign vs_fall_act = active_q ? vs_fall1 : vs_fall0;
    assign target      = auto_en ? auto_tgt_q : deb_q;

    // Switch debounce: synchronised level must differ for DEBOUNCE_CYCLES consecutive clocks.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sw_sync_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sw_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Auto-cycle target; follows the active source whenever auto mode is off.
    always_comb begin
        auto_cnt_d = '0;
        auto_tgt_d = auto_tgt_q;
        if (!auto_en) begin
            auto_tgt_d = active_q;
        end else if (state_q == ST_STABLE) begin
            auto_cnt_d = auto_cnt_q;
            if (vs_fall_act) begin
                if (auto_cnt_q == AUTO_W'(AUTO_FRAMES - 1)) begin
                    auto_tgt_d = ~auto_tgt_q;
                    auto_cnt_d = '0;
                end else begin
                    auto_cnt_d = auto_cnt_q + AUTO_W'(1);
                end
            end
        end
    end

    // Switch FSM; a cancel in WAIT_EDGE wins over a coincident vsync edge.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        blank_cnt_d = blank_cnt_q;
        case (state_q)
            ST_STABLE: begin
                if (target != active_q) begin
                    state_d = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                if (target == active_q) begin
                    state_d = ST_STABLE;
                end else if (vs_fall_act) begin
                    state_d     = ST_BLANK;
                    active_d    = target;
                    blank_cnt_d = '0;
                end
            end
            ST_BLANK: begin
                if (vs_fall_act) begin
                    if (blank_cnt_q == BLANK_W'(BLANK_FRAMES - 1)) begin
                        state_d     = ST_STABLE;
                        blank_cnt_d = '0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_STABLE;
            end
        endcase
    end

    // Output mux keyed on next state so colour blanking lines up with the active_src change.
    always_comb begin
        red_d       = 3'd0;
        green_d     = 3'd0;
        blue_d      = 2'd0;
        hsync_d     = active_d ? src1_hsync : src0_hsync;
        vsync_d     = active_d ? src1_vsync : src0_vsync;
        switching_d = (state_d != ST_STABLE);
        if (state_d != ST_BLANK) begin
            red_d   = active_d ? src1_red   : src0_red;
            green_d = active_d ? src1_green : src0_green;
            blue_d  = active_d ? src1_blue  : src0_blue;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_STABLE;
            active_q    <= 1'b0;
            switching_q <= 1'b0;
            blank_cnt_q <= '0;
            sw_meta_q   <= 1'b0;
            sw_sync_q   <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            auto_cnt_q  <= '0;
            auto_tgt_q  <= 1'b0;
            vs0_prev_q  <= 1'b1;
            vs1_prev_q  <= 1'b1;
            red_q       <= 3'd0;
            green_q     <= 3'd0;
            blue_q      <= 2'd0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            switching_q <= switching_d;
            blank_cnt_q <= blank_cnt_d;
            sw_meta_q   <= sel_sw;
            sw_sync_q   <= sw_meta_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            auto_cnt_q  <= auto_cnt_d;
            auto_tgt_q  <= auto_tgt_d;
            vs0_prev_q  <= src0_vsync;
            vs1_prev_q  <= src1_vsync;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign active_src = active_q;
    assign switching  = switching_q;

endmodule

// File: tb/tb_vga_source_arbiter.sv
// Bench for vga_source_arbiter: table vectors through a scoreboard, then hand sequences
// for debounce, switch, cancel, auto-cycle and reset-during-blank.
module tb_vga_source_arbiter;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
    } pix_t;

    typedef struct {
        pix_t s0;
        pix_t s1;
        pix_t exp;
    } vec_t;

    localparam int P0 = 16;
    localparam int P1 = 12;
    localparam logic [7:0] C0 = {3'd5, 3'd2, 2'd1};
    localparam logic [7:0] C1 = {3'd6, 3'd3, 2'd2};

    logic       clk, rst, sel_sw, auto_en;
    logic [2:0] src0_red, src0_green, src1_red, src1_green;
    logic [1:0] src0_blue, src1_blue;
    logic       src0_hsync, src0_vsync, src1_hsync, src1_vsync;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       hsync, vsync, active_src, switching;

    int   n_chk = 0;
    int   n_err = 0;
    pix_t exp_q[$];
    vec_t tbl[8];

    bit gen_on = 0, hold0 = 0, sb_en = 0, sb_src = 0;
    bit f0_drv = 0, f1_drv = 0, f0_smp = 0, f1_smp = 0;
    int fc0 = 0, fc1 = 0;

    vga_source_arbiter #(
        .DEBOUNCE_CYCLES(4),
        .BLANK_FRAMES   (2),
        .AUTO_FRAMES    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_sw    (sel_sw),
        .auto_en   (auto_en),
        .src0_red  (src0_red),
        .src0_green(src0_green),
        .src0_blue (src0_blue),
        .src0_hsync(src0_hsync),
        .src0_vsync(src0_vsync),
        .src1_red  (src1_red),
        .src1_green(src1_green),
        .src1_blue (src1_blue),
        .src1_hsync(src1_hsync),
        .src1_vsync(src1_vsync),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hsync     (hsync),
        .vsync     (vsync),
        .active_src(active_src),
        .switching (switching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1);
    end

    function automatic pix_t mk(input logic [2:0] r, input logic [2:0] g, input logic [1:0] b,
                                input logic hs, input logic vs);
        pix_t p;
        p.r = r; p.g = g; p.b = b; p.hs = hs; p.vs = vs;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_pix(input pix_t p0, input pix_t p1);
        {src0_red, src0_green, src0_blue, src0_hsync, src0_vsync} = p0;
        {src1_red, src1_green, src1_blue, src1_hsync, src1_vsync} = p1;
    endtask

    // Two free-running renderers with constant colour and short frames.
    task automatic drive_gen();
        logic nv0, nv1;
        pix_t e;
        fc0 = (fc0 + 1) % P0;
        fc1 = (fc1 + 1) % P1;
        nv0 = hold0 ? 1'b1 : (fc0 >= 2);
        nv1 = (fc1 >= 2);
        f0_drv = src0_vsync && !nv0;
        f1_drv = src1_vsync && !nv1;
        src0_vsync = nv0;
        src1_vsync = nv1;
        src0_hsync = (fc0 % 4) != 0;
        src1_hsync = (fc1 % 3) != 0;
        {src0_red, src0_green, src0_blue} = C0;
        {src1_red, src1_green, src1_blue} = C1;
        if (sb_en) begin
            e = sb_src ? {src1_red, src1_green, src1_blue, src1_hsync, src1_vsync}
                       : {src0_red, src0_green, src0_blue, src0_hsync, src0_vsync};
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample after the edge, pop the scoreboard, then drive the next inputs.
    task automatic cyc();
        pix_t e;
        @(posedge clk);
        #1;
        f0_smp = f0_drv;
        f1_smp = f1_drv;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pix", 32'({red, green, blue, hsync, vsync}), 32'(e));
        end
        if (gen_on) begin
            drive_gen();
        end else begin
            f0_drv = 1'b0;
            f1_drv = 1'b0;
        end
    endtask

    initial begin
        int  n, nf;
        bit  bad;

        tbl[0] = '{s0: mk(3'd1, 3'd2, 2'd3, 1'b1, 1'b1), s1: mk(3'd7, 3'd7, 2'd3, 1'b0, 1'b0), exp: mk(3'd1, 3'd2, 2'd3, 1'b1, 1'b1)};
        tbl[1] = '{s0: mk(3'd7, 3'd0, 2'd0, 1'b0, 1'b1), s1: mk(3'd0, 3'd7, 2'd1, 1'b1, 1'b1), exp: mk(3'd7, 3'd0, 2'd0, 1'b0, 1'b1)};
        tbl[2] = '{s0: mk(3'd0, 3'd7, 2'd2, 1'b1, 1'b0), s1: mk(3'd3, 3'd3, 2'd3, 1'b1, 1'b0), exp: mk(3'd0, 3'd7, 2'd2, 1'b1, 1'b0)};
        tbl[3] = '{s0: mk(3'd4, 3'd4, 2'd1, 1'b1, 1'b0), s1: mk(3'd5, 3'd1, 2'd0, 1'b0, 1'b1), exp: mk(3'd4, 3'd4, 2'd1, 1'b1, 1'b0)};
        tbl[4] = '{s0: mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0), s1: mk(3'd7, 3'd7, 2'd3, 1'b1, 1'b1), exp: mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0)};
        tbl[5] = '{s0: mk(3'd7, 3'd7, 2'd3, 1'b1, 1'b1), s1: mk(3'd0, 3'd0, 2'd0, 1'b0, 1'b0), exp: mk(3'd7, 3'd7, 2'd3, 1'b1, 1'b1)};
        tbl[6] = '{s0: mk(3'd2, 3'd5, 2'd1, 1'b0, 1'b1), s1: mk(3'd6, 3'd2, 2'd2, 1'b1, 1'b0), exp: mk(3'd2, 3'd5, 2'd1, 1'b0, 1'b1)};
        tbl[7] = '{s0: mk(3'd3, 3'd6, 2'd2, 1'b1, 1'b1), s1: mk(3'd1, 3'd1, 2'd1, 1'b0, 1'b1), exp: mk(3'd3, 3'd6, 2'd2, 1'b1, 1'b1)};

        // Reset with the switch already thrown and live source data
        rst = 1'b1; sel_sw = 1'b1; auto_en = 1'b0;
        drive_pix(mk(3'd5, 3'd5, 2'd3, 1'b0, 1'b0), mk(3'd6, 3'd6, 2'd2, 1'b0, 1'b0));
        #1 rst = 1'b0;
        #2;
        chk("rst_colour", 32'({red, green, blue}), 32'(0));
        chk("rst_syncs", 32'({hsync, vsync}), 32'(2'b11));
        chk("rst_active", 32'(active_src), 32'(0));
        chk("rst_switching", 32'(switching), 32'(0));
        cyc();
        cyc();
        chk("rst_hold_out", 32'({red, green, blue, hsync, vsync}), 32'(10'b0000000011));
        sel_sw = 1'b0;
        rst = 1'b1;

        // Table vectors: src0 passes through with one clock of latency
        for (int i = 0; i < 8; i++) begin
            drive_pix(tbl[i].s0, tbl[i].s1);
            exp_q.push_back(tbl[i].exp);
            cyc();
        end
        cyc();

        // Debounce: a 3-clock glitch is rejected
        gen_on = 1'b1; hold0 = 1'b1; sb_en = 1'b1; sb_src = 1'b0;
        cyc();
        sel_sw = 1'b1;
        cyc(); cyc(); cyc();
        sel_sw = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (switching !== 1'b0) bad = 1'b1;
        end
        chk("glitch_no_wait", 32'(bad), 32'(0));

        // A held switch reaches WAIT_EDGE exactly 7 clocks later
        sel_sw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk($sformatf("deb_wait_k%0d", k), 32'(switching), (k == 7) ? 32'(1) : 32'(0));
        end

        // Cancel before any src0 vsync edge: back to STABLE, colour never blanked
        sel_sw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk($sformatf("cancel_k%0d", k), 32'(switching), (k < 7) ? 32'(1) : 32'(0));
        end
        chk("cancel_active", 32'(active_src), 32'(0));
        hold0 = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (switching !== 1'b0 || active_src !== 1'b0) bad = 1'b1;
        end
        chk("cancel_stays_stable", 32'(bad), 32'(0));

        // Switch src0 -> src1 on a src0 vsync fall, blank two src1 frames
        sb_en = 1'b0;
        sel_sw = 1'b1;
        n = 0;
        while (switching !== 1'b1 && n < 60) begin cyc(); n++; end
        chk("sw_enter_wait", 32'(switching), 32'(1));
        n = 0;
        do begin cyc(); n++; end while (!f0_smp && n < 60);
        chk("sw_edge_seen", 32'(f0_smp), 32'(1));
        chk("sw_active1", 32'(active_src), 32'(1));
        chk("sw_switching", 32'(switching), 32'(1));
        chk("sw_blank_first", 32'({red, green, blue}), 32'(0));
        nf = 0; n = 0; bad = 1'b0;
        while (nf < 2 && n < 80) begin
            cyc(); n++;
            if (f1_smp) nf++;
            if (nf < 2 && {red, green, blue} !== 8'd0) bad = 1'b1;
        end
        chk("blank_colour", 32'(bad), 32'(0));
        chk("blank_frames", 32'(nf), 32'(2));
        chk("blank_end_switching", 32'(switching), 32'(0));
        chk("blank_end_colour", 32'({red, green, blue}), 32'(C1));
        chk("blank_end_active", 32'(active_src), 32'(1));
        sb_en = 1'b1; sb_src = 1'b1;
        for (int k = 0; k < 20; k++) cyc();

        // Auto mode from src1: three counted frames, one wait frame, then blank
        sb_en = 1'b0;
        auto_en = 1'b1; sel_sw = 1'b0;
        nf = 0; n = 0; bad = 1'b0;
        while (nf < 4 && n < 200) begin
            cyc(); n++;
            if (f1_smp) nf++;
            if (nf < 4 && active_src !== 1'b1) bad = 1'b1;
        end
        chk("auto_hold_src1", 32'(bad), 32'(0));
        chk("auto_frames1", 32'(nf), 32'(4));
        chk("auto_to_src0", 32'(active_src), 32'(0));
        chk("auto_blank0", 32'({red, green, blue}), 32'(0));
        sel_sw = 1'b1;
        nf = 0; n = 0; bad = 1'b0;
        while (nf < 6 && n < 300) begin
            cyc(); n++;
            if (f0_smp) begin
                nf++;
                if (nf == 2) begin
                    chk("auto_blank_end_sw", 32'(switching), 32'(0));
                    chk("auto_blank_end_colour", 32'({red, green, blue}), 32'(C0));
                end
            end
            if (nf < 6 && active_src !== 1'b0) bad = 1'b1;
        end
        chk("auto_hold_src0", 32'(bad), 32'(0));
        chk("auto_frames0", 32'(nf), 32'(6));
        chk("auto_to_src1", 32'(active_src), 32'(1));

        // Reset asserted in the middle of BLANK
        cyc();
        chk("pre_rst_switching", 32'(switching), 32'(1));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_colour", 32'({red, green, blue}), 32'(0));
        chk("mid_rst_syncs", 32'({hsync, vsync}), 32'(2'b11));
        chk("mid_rst_active", 32'(active_src), 32'(0));
        chk("mid_rst_switching", 32'(switching), 32'(0));
        auto_en = 1'b0; sel_sw = 1'b0;
        exp_q.delete();
        cyc();
        rst = 1'b1;
        sb_en = 1'b1; sb_src = 1'b0;
        for (int k = 0; k < 20; k++) cyc();
        chk("post_rst_active", 32'(active_src), 32'(0));
        chk("post_rst_switching", 32'(switching), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
